// File: rtl/z_group1_mul_post_pkg.sv
// Shared invsqrt constants: group-1 datapath widths, Q-format integer bits and rounding modes.
package z_group1_mul_post_pkg;

    localparam int unsigned G1_A_W     = 33;
    localparam int unsigned G1_B_W     = 47;
    localparam int unsigned G1_P_W     = G1_A_W + G1_B_W;
    localparam int unsigned G1_OUT_W   = 47;
    localparam int unsigned G1_EXP_W   = 10;
    localparam int unsigned G1_MUL_LAT = 2;

    // Product is Q2.(P_W-2); normalised mantissa is Q1.(OUT_W-1).
    localparam int unsigned P_INT_BITS    = 2;
    localparam int unsigned MANT_INT_BITS = 1;

    typedef enum logic [0:0] {
        RndRne,
        RndRtz
    } round_mode_e;

endpackage

// File: rtl/z_group1_rne_round.sv
// Combinational normalise + round of a Q2 product to a Q1 mantissa with exponent adjust.
// Shared by the group-1 and group-2 post stages.
module z_group1_rne_round
    import z_group1_mul_post_pkg::*;
#(
    parameter int unsigned P_W   = G1_P_W,
    parameter int unsigned OUT_W = G1_OUT_W,
    parameter int unsigned EXP_W = G1_EXP_W,
    parameter round_mode_e MODE  = RndRne
) (
    input  logic [P_W-1:0]   p_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic [OUT_W-1:0] mant_o,
    output logic [EXP_W-1:0] exp_o,
    output logic             zero_o,
    output logic             ovf_o
);

    // Leading bit position when the product is below 2.0.
    localparam int unsigned LO_TOP = P_W - P_INT_BITS;
    localparam logic [OUT_W-1:0] MANT_ONE = OUT_W'(1) << (OUT_W - MANT_INT_BITS);

    logic             hi;
    logic [OUT_W-1:0] m;
    logic             g;
    logic             s;
    logic             rnd_up;
    logic [EXP_W:0]   e;

    assign hi = p_i[P_W-1];

    always_comb begin
        if (hi) begin
            m = p_i[P_W-1 -: OUT_W];
            g = p_i[P_W-1-OUT_W];
            s = |p_i[P_W-2-OUT_W:0];
        end else begin
            m = p_i[LO_TOP -: OUT_W];
            g = p_i[LO_TOP-OUT_W];
            s = |p_i[LO_TOP-1-OUT_W:0];
        end
    end

    assign rnd_up = (MODE == RndRne) ? (g & (s | m[0])) : 1'b0;

    always_comb begin
        mant_o = m;
        e      = {1'b0, exp_i} + {{EXP_W{1'b0}}, hi};
        if (rnd_up) begin
            // All-ones mantissa rolls over to 1.0 of the next binade.
            if (&m) begin
                mant_o = MANT_ONE;
                e      = e + (EXP_W+1)'(1);
            end else begin
                mant_o = m + OUT_W'(1);
            end
        end
        zero_o = 1'b0;
        ovf_o  = 1'b0;
        exp_o  = e[EXP_W-1:0];
        if (p_i == '0) begin
            zero_o = 1'b1;
            mant_o = '0;
            exp_o  = exp_i;
        end else if (e[EXP_W]) begin
            ovf_o  = 1'b1;
            mant_o = '1;
            exp_o  = '1;
        end
    end

endmodule

// File: rtl/z_group1_mul_post.sv
// Group-1 invsqrt multiplier post stage: multiplier enable, exponent/valid tag line
// and registered normalise/round result on a valid/ready interface.
module z_group1_mul_post
    import z_group1_mul_post_pkg::*;
#(
    parameter int unsigned A_W     = G1_A_W,
    parameter int unsigned B_W     = G1_B_W,
    parameter int unsigned OUT_W   = G1_OUT_W,
    parameter int unsigned EXP_W   = G1_EXP_W,
    parameter int unsigned MUL_LAT = G1_MUL_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [EXP_W-1:0]     in_exp,
    output logic                 in_ready,
    output logic                 mul_ce,
    input  logic [A_W+B_W-1:0]   p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_mant,
    output logic [EXP_W-1:0]     out_exp,
    output logic                 out_zero,
    output logic                 out_ovf
);

    localparam int unsigned P_W = A_W + B_W;

    logic               stall;
    logic [MUL_LAT-1:0] tag_v_q;
    logic [EXP_W-1:0]   tag_e_q [MUL_LAT];

    logic [OUT_W-1:0]   rnd_mant;
    logic [EXP_W-1:0]   rnd_exp;
    logic               rnd_zero;
    logic               rnd_ovf;

    logic               out_valid_q;
    logic [OUT_W-1:0]   out_mant_q;
    logic [EXP_W-1:0]   out_exp_q;
    logic               out_zero_q;
    logic               out_ovf_q;

    // A held result freezes the multiplier and tag line together so they stay aligned.
    assign stall    = out_valid_q & ~out_ready;
    assign mul_ce   = ce & ~stall;
    assign in_ready = mul_ce;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_e_q[i] <= '0;
            end
        end else if (mul_ce) begin
            tag_v_q[0] <= in_valid;
            tag_e_q[0] <= in_exp;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_e_q[i] <= tag_e_q[i-1];
            end
        end
    end

    z_group1_rne_round #(
        .P_W   (P_W),
        .OUT_W (OUT_W),
        .EXP_W (EXP_W),
        .MODE  (RndRne)
    ) u_round (
        .p_i    (p),
        .exp_i  (tag_e_q[MUL_LAT-1]),
        .mant_o (rnd_mant),
        .exp_o  (rnd_exp),
        .zero_o (rnd_zero),
        .ovf_o  (rnd_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else if (mul_ce) begin
            out_valid_q <= tag_v_q[MUL_LAT-1];
            if (tag_v_q[MUL_LAT-1]) begin
                out_mant_q <= rnd_mant;
                out_exp_q  <= rnd_exp;
                out_zero_q <= rnd_zero;
                out_ovf_q  <= rnd_ovf;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_mant  = out_mant_q;
    assign out_exp   = out_exp_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;

endmodule
